// File: rtl/auto_player_pkg.sv
// auto_player_pkg: FSM states, controller outcome codes, sweep constants
// and the rule deciding whether a reported outcome matches the hands.
package auto_player_pkg;

  localparam int NUM_SEEDS = 64;
  localparam int MAX_HITS  = 3;
  localparam int BUST      = 21;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_LO,
    S_RST_WAIT,
    S_BEGIN_LO,
    S_BEGIN_GAP,
    S_HIT_LO,
    S_HIT_GAP,
    S_STAND_LO,
    S_SETTLE,
    S_SUM,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OC_NONE   = 2'd0,
    OC_PLAYER = 2'd1,
    OC_HOUSE  = 2'd2,
    OC_PUSH   = 2'd3
  } outcome_e;

  // Both-bust with equal sums is consistent with HOUSE and PUSH alike.
  function automatic logic outcome_ok(
    input logic [5:0] p,
    input logic [5:0] h,
    input outcome_e   oc
  );
    logic pb;
    logic hb;
    pb = p > 6'(BUST);
    hb = h > 6'(BUST);
    case (oc)
      OC_PLAYER: outcome_ok = !pb && (p > h || hb);
      OC_HOUSE:  outcome_ok = pb || (h > p && !hb);
      OC_PUSH:   outcome_ok = (p == h);
      default:   outcome_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/card_value.sv
// card_value: maps a 4-bit card code to its blackjack score.
// Ports: card_i (code), score_o (0, 2..11).
module card_value (
  input  logic [3:0] card_i,
  output logic [5:0] score_o
);

  always_comb begin
    score_o = 6'd0;
    if (card_i == 4'd1) begin
      score_o = 6'd11;
    end else if (card_i >= 4'd2 && card_i <= 4'd10) begin
      score_o = {2'b00, card_i};
    end else if (card_i >= 4'd11 && card_i <= 4'd13) begin
      score_o = 6'd10;
    end
  end

endmodule

// File: rtl/auto_player.sv
// auto_player: sweeps 64 seeds x 0..3 hits against a blackjack controller,
// pressing its active-low buttons and tallying outcome consistency.
// Ports: clk, rst (sync, active-low), start, hands, game_outcome in;
// ctrl_rst_n/ready_n/hit_n/stand_n, seed_out, correct, incorrect,
// busy, done out. Define AUTO_PLAYER_HALT_ON_FAIL_EN to stop at the
// first incorrect game and expose fail_hits.
module auto_player
  import auto_player_pkg::*;
#(
  parameter int PULSE_LEN  = 10,
  parameter int RST_WAIT   = 350,
  parameter int SETTLE_LEN = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [39:0] hands,
  input  logic [1:0]  game_outcome,
  output logic        ctrl_rst_n,
  output logic        ready_n,
  output logic        hit_n,
  output logic        stand_n,
  output logic [5:0]  seed_out,
  output logic [9:0]  correct,
  output logic [9:0]  incorrect,
  output logic        busy,
`ifdef AUTO_PLAYER_HALT_ON_FAIL_EN
  output logic [1:0]  fail_hits,
`endif
  output logic        done
);

  localparam logic [15:0] PL_M1  = 16'(PULSE_LEN - 1);
  localparam logic [15:0] RW_M1  = 16'(RST_WAIT - 1);
  localparam logic [15:0] SL_M1  = 16'(SETTLE_LEN - 1);
  localparam logic [15:0] SUM_M1 = 16'd4;
  localparam logic [5:0]  SEED_L = 6'(NUM_SEEDS - 1);
  localparam logic [1:0]  HITS_L = 2'(MAX_HITS);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  seed_q, seed_d;
  logic [1:0]  hits_q, hits_d;
  logic [1:0]  hidx_q, hidx_d;
  logic [5:0]  pacc_q, pacc_d;
  logic [5:0]  hacc_q, hacc_d;
  logic [9:0]  cor_q, cor_d;
  logic [9:0]  inc_q, inc_d;
  logic [3:0]  btn_q, btn_d;

  logic [4:0]  boff;
  logic [3:0]  p_card, h_card;
  logic [5:0]  p_score, h_score;
  logic        ok;

  // Nibble i of each hand is selected by the SUM cycle index.
  assign boff   = {cnt_q[2:0], 2'b00};
  assign p_card = 4'(hands[19:0] >> boff);
  assign h_card = 4'(hands[39:20] >> boff);

  card_value u_pval (.card_i(p_card), .score_o(p_score));
  card_value u_hval (.card_i(h_card), .score_o(h_score));

  assign ok = outcome_ok(pacc_q, hacc_q, outcome_e'(game_outcome));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    seed_d  = seed_q;
    hits_d  = hits_q;
    hidx_d  = hidx_q;
    pacc_d  = pacc_q;
    hacc_d  = hacc_q;
    cor_d   = cor_q;
    inc_d   = inc_q;
    btn_d   = 4'hF;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_RST_LO;
          seed_d  = '0;
          hits_d  = '0;
          cor_d   = '0;
          inc_d   = '0;
        end
      end
      S_RST_LO:
        if (cnt_q == PL_M1) state_d = S_RST_WAIT;
      S_RST_WAIT:
        if (cnt_q == RW_M1) state_d = S_BEGIN_LO;
      S_BEGIN_LO:
        if (cnt_q == PL_M1) state_d = S_BEGIN_GAP;
      S_BEGIN_GAP:
        if (cnt_q == PL_M1) begin
          hidx_d  = '0;
          state_d = (hits_q == 2'd0) ? S_STAND_LO : S_HIT_LO;
        end
      S_HIT_LO:
        if (cnt_q == PL_M1) state_d = S_HIT_GAP;
      S_HIT_GAP:
        if (cnt_q == PL_M1) begin
          if (hidx_q == hits_q - 2'd1) begin
            state_d = S_STAND_LO;
          end else begin
            hidx_d  = hidx_q + 2'd1;
            state_d = S_HIT_LO;
          end
        end
      S_STAND_LO:
        if (cnt_q == PL_M1) state_d = S_SETTLE;
      S_SETTLE:
        if (cnt_q == SL_M1) begin
          pacc_d  = '0;
          hacc_d  = '0;
          state_d = S_SUM;
        end
      S_SUM: begin
        pacc_d = pacc_q + p_score;
        hacc_d = hacc_q + h_score;
        if (cnt_q == SUM_M1) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_NEXT;
        if (ok) begin
          if (cor_q != 10'h3FF) cor_d = cor_q + 10'd1;
        end else begin
          if (inc_q != 10'h3FF) inc_d = inc_q + 10'd1;
`ifdef AUTO_PLAYER_HALT_ON_FAIL_EN
          state_d = S_DONE;
`endif
        end
      end
      S_NEXT: begin
        state_d = S_RST_LO;
        if (hits_q == HITS_L) begin
          if (seed_q == SEED_L) begin
            state_d = S_DONE;
          end else begin
            hits_d = '0;
            seed_d = seed_q + 6'd1;
          end
        end else begin
          hits_d = hits_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Buttons are registered from the next state so they line up
    // exactly with the state cycles and never glitch.
    unique case (state_d)
      S_RST_LO:   btn_d[3] = 1'b0;
      S_BEGIN_LO: btn_d[2] = 1'b0;
      S_HIT_LO:   btn_d[1] = 1'b0;
      S_STAND_LO: btn_d[0] = 1'b0;
      default:    btn_d    = 4'hF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
      hits_q  <= '0;
      hidx_q  <= '0;
      pacc_q  <= '0;
      hacc_q  <= '0;
      cor_q   <= '0;
      inc_q   <= '0;
      btn_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      hits_q  <= hits_d;
      hidx_q  <= hidx_d;
      pacc_q  <= pacc_d;
      hacc_q  <= hacc_d;
      cor_q   <= cor_d;
      inc_q   <= inc_d;
      btn_q   <= btn_d;
    end
  end

  assign {ctrl_rst_n, ready_n, hit_n, stand_n} = btn_q;
  assign seed_out  = seed_q;
  assign correct   = cor_q;
  assign incorrect = inc_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef AUTO_PLAYER_HALT_ON_FAIL_EN
  assign fail_hits = hits_q;
`endif

endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player: randomized controller model with a tally scoreboard
// and button-timing monitor for auto_player.
module tb_auto_player;

  localparam int PL = 2;
  localparam int RW = 3;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [39:0] hands = '0;
  logic [1:0]  game_outcome = '0;
  logic        ctrl_rst_n, ready_n, hit_n, stand_n;
  logic [5:0]  seed_out;
  logic [9:0]  correct, incorrect;
  logic        busy, done;
`ifdef AUTO_PLAYER_HALT_ON_FAIL_EN
  logic [1:0]  fail_hits;
`endif

  int nchk = 0;
  int nerr = 0;
  int mode = 0;
  int game = 0;
  int exp_cor = 0;
  int exp_inc = 0;
  int ncyc = 0;
  bit mon_en = 1'b0;
  bit exp_q[$];

  always #5 clk = ~clk;

  auto_player #(
    .PULSE_LEN(PL), .RST_WAIT(RW), .SETTLE_LEN(SL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .hands(hands), .game_outcome(game_outcome),
    .ctrl_rst_n(ctrl_rst_n), .ready_n(ready_n),
    .hit_n(hit_n), .stand_n(stand_n),
    .seed_out(seed_out), .correct(correct),
    .incorrect(incorrect), .busy(busy),
`ifdef AUTO_PLAYER_HALT_ON_FAIL_EN
    .fail_hits(fail_hits),
`endif
    .done(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int cval(input int c);
    if (c == 1) return 11;
    if (c >= 2 && c <= 10) return c;
    if (c >= 11 && c <= 13) return 10;
    return 0;
  endfunction

  function automatic int score(input logic [19:0] n);
    int s = 0;
    for (int i = 0; i < 5; i++) s += cval(int'(n[i*4 +: 4]));
    return s;
  endfunction

  function automatic bit consistent(input int p, input int h,
                                    input int oc);
    if (oc == 1) return (p <= 21) && (p > h || h > 21);
    if (oc == 2) return (p > 21) || (h > p && h <= 21);
    if (oc == 3) return p == h;
    return 1'b0;
  endfunction

  // Directed games: {10,11} vs {9,8}; {1,13,5} vs {10,7}.
  int dp[4]  = '{'h000BA, 'h000BA, 'h005D1, 'h005D1};
  int dh[4]  = '{'h00089, 'h00089, 'h0007A, 'h0007A};
  int doc[4] = '{2, 1, 2, 0};
  int dok[4] = '{0, 1, 1, 0};

  // Controller model: new hands/outcome at each ctrl reset press.
  bit prev_crn = 1'b1;
  always @(negedge clk) begin
    logic [19:0] pn, hn;
    int oc, p, h, r, c, kp, kh;
    bit ok;
    if (!rst) begin
      exp_q.delete();
      game = 0; exp_cor = 0; exp_inc = 0;
      prev_crn = 1'b1;
    end else begin
      if (start && !busy) begin
        game = 0; exp_cor = 0; exp_inc = 0;
        exp_q.delete();
      end
      if (prev_crn && !ctrl_rst_n) begin
        chk("game_seed", int'(seed_out), game / 4);
        kp = $urandom_range(2, 5);
        kh = $urandom_range(2, 5);
        pn = 20'($urandom) & 20'((1 << (4 * kp)) - 1);
        hn = 20'($urandom) & 20'((1 << (4 * kh)) - 1);
        p = score(pn);
        h = score(hn);
        oc = $urandom_range(0, 3);
        if (mode != 1) begin
          r = $urandom_range(0, 2);
          oc = 0;
          for (int k = 0; k < 3; k++) begin
            c = 1 + (r + k) % 3;
            if (oc == 0 && consistent(p, h, c)) oc = c;
          end
          if (mode == 2 && game == 29) oc = 0;
        end
        ok = consistent(p, h, oc);
        if (mode == 1 && game < 4) begin
          pn = 20'(dp[game]);
          hn = 20'(dh[game]);
          oc = doc[game];
          ok = dok[game][0];
        end
        hands = {hn, pn};
        game_outcome = 2'(oc);
        exp_q.push_back(ok);
        if (ok) exp_cor++; else exp_inc++;
        game++;
      end
      prev_crn = ctrl_rst_n;
    end
  end

  // Monitor: button windows, gaps, hit counts and tally scoreboard.
  int low_len[4];
  int rel_cyc = -100;
  int hit_falls = 0;
  int pcor = 0;
  int pinc = 0;
  logic [3:0] pb = 4'hF;
  string bn[4] = '{"w_stand", "w_hit", "w_ready", "w_rst"};
  always @(negedge clk) begin
    logic [3:0] b;
    bit e;
    ncyc++;
    b = {ctrl_rst_n, ready_n, hit_n, stand_n};
    if (!mon_en) begin
      for (int i = 0; i < 4; i++) low_len[i] = 0;
      pb = 4'hF; hit_falls = 0; rel_cyc = -100;
    end else begin
      if (b != 4'hF) chk("one_low", $countones(~b), 1);
      for (int i = 0; i < 4; i++) begin
        if (!b[i]) begin
          low_len[i]++;
        end else if (low_len[i] != 0) begin
          chk(bn[i], low_len[i], PL);
          low_len[i] = 0;
        end
      end
      if (b[2] && !pb[2]) rel_cyc = ncyc;
      if (b[1] && !pb[1]) rel_cyc = ncyc;
      if (!b[3] && pb[3]) hit_falls = 0;
      if (!b[1] && pb[1]) begin
        hit_falls++;
        chk("hit_gap", ncyc - rel_cyc, PL);
      end
      if (!b[0] && pb[0]) begin
        chk("stand_gap", ncyc - rel_cyc, PL);
        chk("hit_count", hit_falls, (game - 1) % 4);
        chk("stand_seed", int'(seed_out), (game - 1) / 4);
      end
      pb = b;
    end
    if (int'(correct) != pcor || int'(incorrect) != pinc) begin
      if (correct != 0 || incorrect != 0) begin
        if (exp_q.size() == 0) begin
          chk("tally_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tally_correct", int'(correct), pcor + (e ? 1 : 0));
          chk("tally_incorrect", int'(incorrect), pinc + (e ? 0 : 1));
        end
      end
      pcor = int'(correct);
      pinc = int'(incorrect);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_sweep(input string tag);
    bit fin = 1'b0;
    pulse_start();
    @(negedge clk);
    chk({tag, "_busy_start"}, int'(busy), 1);
    chk({tag, "_done_clr"}, int'(done), 0);
    chk({tag, "_cnt_clr"}, int'(correct) + int'(incorrect), 0);
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, int'(fin), 1);
    chk({tag, "_games"}, game, 256);
    chk({tag, "_correct"}, int'(correct), exp_cor);
    chk({tag, "_incorrect"}, int'(incorrect), exp_inc);
    chk({tag, "_seed_end"}, int'(seed_out), 63);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    bit hit;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_buttons", int'({ctrl_rst_n, ready_n, hit_n, stand_n}), 15);
    chk("rst_correct", int'(correct), 0);
    chk("rst_incorrect", int'(incorrect), 0);
    chk("rst_seed", int'(seed_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b1;
    mon_en = 1'b1;

    mode = 0;
    run_sweep("s1");
    chk("s1_all_correct", int'(correct), 256);
    chk("s1_none_wrong", int'(incorrect), 0);

`ifndef AUTO_PLAYER_HALT_ON_FAIL_EN
    mode = 1;
    run_sweep("s2");
`endif

    mode = 0;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (seed_out == 6'd2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_seed2", int'(hit), 1);
    pulse_start();
    @(negedge clk);
    chk("ign_start_busy", int'(busy), 1);
    chk("ign_start_seed", int'(seed_out), 2);
    chk("ign_start_tally", int'(correct), 8);

    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (seed_out == 6'd5 && !hit_n) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_seed5_hit", int'(hit), 1);
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_hit_n", int'(hit_n), 1);
    chk("mid_seed", int'(seed_out), 0);
    chk("mid_correct", int'(correct), 0);
    chk("mid_incorrect", int'(incorrect), 0);
    chk("mid_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;

`ifdef AUTO_PLAYER_HALT_ON_FAIL_EN
    mode = 2;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (done) begin
        hit = 1'b1;
        break;
      end
    end
    chk("halt_done", int'(hit), 1);
    chk("halt_seed", int'(seed_out), 7);
    chk("halt_hits", int'(fail_hits), 1);
    chk("halt_incorrect", int'(incorrect), 1);
    chk("halt_correct", int'(correct), 29);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
